// File: rtl/key_pkg.sv
// Shared encodings for the key event arbiter: event types, tracker states
// and a sizing helper for the key index width.
package key_pkg;

  localparam int CNT_W = 26;

  localparam logic [1:0] EVT_PRESS  = 2'b00;
  localparam logic [1:0] EVT_LONG   = 2'b01;
  localparam logic [1:0] EVT_REPEAT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_REPT = 2'b10
  } trk_state_t;

  function automatic int key_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module key_evt_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_arb.sv
// Key event arbiter: queues press events, tracks one held key for long-press
// and auto-repeat events, and reports events lost to back-pressure.
module key_event_arb
  import key_pkg::*;
#(
  parameter int KEY_W       = 2,
  parameter int LONG_TIME   = 50_000_000,
  parameter int REPEAT_TIME = 10_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [KEY_W-1:0]            key_down,
  input  logic [KEY_W-1:0]            key_lvl,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [key_idw(KEY_W)-1:0]   evt_key,
  output logic [1:0]                  evt_type,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt
);

  // state | meaning
  // IDLE  | no key tracked; next granted press starts tracking
  // HOLD  | tracked key held, counting toward the long-press event
  // REPT  | long press issued, counting between auto-repeat events

  localparam int IDW = key_idw(KEY_W);
  localparam int QW  = IDW + 2;
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_TIME - 1);

  logic [KEY_W-1:0] pend;
  logic             trk_pend;
  logic [1:0]       trk_pend_type;
  trk_state_t       state;
  trk_state_t       state_nxt;
  logic [IDW-1:0]   trk;
  logic [CNT_W-1:0] cnt;
  logic [IDW-1:0]   rr_ptr;

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             can_push;
  logic             push;
  logic [QW-1:0]    push_data;
  logic [QW-1:0]    pop_data;

  logic             key_hit;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_trk;
  logic             gnt_key;
  logic [KEY_W-1:0] gnt_oh;

  logic             trk_rel;
  logic             trk_load;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             trk_raise;
  logic [1:0]       trk_raise_type;

  logic [KEY_W-1:0] lost_key;
  logic             trk_lost;
  logic [8:0]       lost_n;
  logic [9:0]       drop_sum;

  assign pop       = evt_valid && evt_ready;
  assign evt_valid = !fifo_empty;
  assign can_push  = !fifo_full || pop;
  assign evt_key   = pop_data[QW-1:2];
  assign evt_type  = pop_data[1:0];

  // Round-robin search starts at rr_ptr, which holds the key after the last grant.
  always_comb begin
    logic [IDW-1:0] cand;
    int j;
    key_hit = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    j       = 0;
    for (int i = 0; i < KEY_W; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= KEY_W) j = j - KEY_W;
      cand = IDW'(j);
      if (!key_hit && pend[cand]) begin
        key_hit = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_trk   = can_push && trk_pend;
  assign gnt_key   = can_push && !trk_pend && key_hit;
  assign gnt_oh    = gnt_key ? (KEY_W'(1) << gnt_idx) : '0;
  assign push      = gnt_trk || gnt_key;
  assign push_data = gnt_trk ? {trk, trk_pend_type} : {gnt_idx, EVT_PRESS};

  assign trk_rel   = key_lvl[trk];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (gnt_key) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (trk_rel)             state_nxt = ST_IDLE;
        else if (cnt == LONG_TC) state_nxt = ST_REPT;
      end
      ST_REPT: if (trk_rel) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Release wins over expiry: a released key raises nothing in that cycle.
  always_comb begin
    trk_load       = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    trk_raise      = 1'b0;
    trk_raise_type = EVT_LONG;
    case (state)
      ST_IDLE: begin
        trk_load = gnt_key;
        cnt_clr  = gnt_key;
      end
      ST_HOLD: begin
        if (!trk_rel) begin
          if (cnt == LONG_TC) begin
            trk_raise = 1'b1;
            cnt_clr   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_REPT: begin
        if (!trk_rel) begin
          if (cnt == REP_TC) begin
            trk_raise      = 1'b1;
            trk_raise_type = EVT_REPEAT;
            cnt_clr        = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign lost_key = key_down & pend & ~gnt_oh;
  assign trk_lost = trk_raise && trk_pend && !gnt_trk;

  always_comb begin
    lost_n = 9'(trk_lost);
    for (int i = 0; i < KEY_W; i++) lost_n = lost_n + 9'(lost_key[i]);
  end

  assign drop_sum = 10'(drop_cnt) + 10'(lost_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend          <= '0;
      trk_pend      <= 1'b0;
      trk_pend_type <= EVT_PRESS;
      trk           <= '0;
      cnt           <= '0;
      rr_ptr        <= '0;
      overflow      <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      pend <= (pend & ~gnt_oh) | key_down;
      if (trk_raise && !trk_lost) begin
        trk_pend      <= 1'b1;
        trk_pend_type <= trk_raise_type;
      end else if (gnt_trk) begin
        trk_pend <= 1'b0;
      end
      if (trk_load) trk <= gnt_idx;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (gnt_key) rr_ptr <= (gnt_idx == IDW'(KEY_W - 1)) ? '0 : gnt_idx + IDW'(1);
      overflow <= (lost_n != '0);
      drop_cnt <= (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
    end
  end

  key_evt_fifo #(
    .W     (QW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_key_event_arb.sv
// Scoreboard bench for key_event_arb: directed presses/holds push expected
// events; a monitor pops and compares each accepted event.
module tb_key_event_arb;
  import key_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_down;
  logic [1:0] key_lvl;
  logic       evt_valid;
  logic       evt_ready;
  logic [0:0] evt_key;
  logic [1:0] evt_type;
  logic       overflow;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  logic [2:0] exp_q[$];
  int pop_cyc_q[$];
  logic [2:0] mon_e;

  key_event_arb #(
    .KEY_W       (2),
    .LONG_TIME   (20),
    .REPEAT_TIME (8),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_down  (key_down),
    .key_lvl   (key_lvl),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_type  (evt_type),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic press(input logic [1:0] k);
    key_down = k;
    tick();
    key_down = 2'b00;
  endtask

  task automatic expect_evt(input logic k, input logic [1:0] t);
    exp_q.push_back({k, t});
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      tick();
      budget++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (overflow) ovf_cnt++;
        if (evt_valid && evt_ready) begin
          pop_cyc_q.push_back(cyc);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL evt_unexpected: got key=%0d type=%0d, required no event", evt_key, evt_type);
          end else begin
            mon_e = exp_q.pop_front();
            if ({evt_key, evt_type} !== mon_e) begin
              n_bad++;
              $display("FAIL evt_order: got key=%0d type=%0d, required key=%0d type=%0d",
                       evt_key, evt_type, mon_e[2], mon_e[1:0]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst_n     = 1'b1;
    key_down  = 2'b00;
    key_lvl   = 2'b11;
    evt_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_evt_valid", int'(evt_valid), 0);
    check("rst_evt_key", int'(evt_key), 0);
    check("rst_evt_type", int'(evt_type), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    tick();
    tick();
    rst_n = 1'b1;

    // single press at cycle 10, visible two cycles later
    while (cyc < 10) tick();
    expect_evt(1'b0, EVT_PRESS);
    press(2'b01);
    check("latency_n1", int'(evt_valid), 0);
    tick();
    check("latency_n2", int'(evt_valid), 1);
    check("latency_key", int'(evt_key), 0);
    check("latency_type", int'(evt_type), int'(EVT_PRESS));
    drain();

    // round-robin ordering of simultaneous presses
    expect_evt(1'b1, EVT_PRESS);
    press(2'b10);
    drain();
    expect_evt(1'b0, EVT_PRESS);
    expect_evt(1'b1, EVT_PRESS);
    press(2'b11);
    drain();
    expect_evt(1'b0, EVT_PRESS);
    press(2'b01);
    drain();
    expect_evt(1'b1, EVT_PRESS);
    expect_evt(1'b0, EVT_PRESS);
    press(2'b11);
    drain();

    // key 1 held: press, long, two repeats, then release stops events
    pop_cyc_q.delete();
    key_lvl = 2'b01;
    expect_evt(1'b1, EVT_PRESS);
    expect_evt(1'b1, EVT_LONG);
    expect_evt(1'b1, EVT_REPEAT);
    expect_evt(1'b1, EVT_REPEAT);
    press(2'b10);
    repeat (39) tick();
    key_lvl = 2'b11;
    repeat (30) tick();
    check("hold_remaining", exp_q.size(), 0);
    check("hold_evt_count", pop_cyc_q.size(), 4);
    if (pop_cyc_q.size() == 4) begin
      check("long_delay", pop_cyc_q[1] - pop_cyc_q[0], 21);
      check("repeat1_delay", pop_cyc_q[2] - pop_cyc_q[1], 8);
      check("repeat2_delay", pop_cyc_q[3] - pop_cyc_q[2], 8);
    end

    // back-pressure: 4 queued, 1 pending, 1 lost
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_evt(1'b0, EVT_PRESS);
    for (int i = 0; i < 6; i++) begin
      press(2'b01);
      tick();
      tick();
    end
    check("bp_drop_cnt", int'(drop_cnt), 1);
    check("bp_overflow_pulses", ovf_cnt, 1);
    check("bp_valid", int'(evt_valid), 1);
    evt_ready = 1'b1;
    drain();

    // full FIFO with push and pop in the same cycle
    evt_ready = 1'b0;
    expect_evt(1'b0, EVT_PRESS);
    expect_evt(1'b1, EVT_PRESS);
    expect_evt(1'b0, EVT_PRESS);
    expect_evt(1'b1, EVT_PRESS);
    expect_evt(1'b1, EVT_PRESS);
    press(2'b01); tick(); tick();
    press(2'b10); tick(); tick();
    press(2'b01); tick(); tick();
    press(2'b10); tick(); tick();
    press(2'b10); tick(); tick();
    check("full_pend_held", int'(dut.pend), 2);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("full_same_cycle_push", int'(dut.pend), 0);
    check("full_count", int'(dut.u_fifo.count), 4);
    check("full_no_loss_drop", int'(drop_cnt), 1);
    check("full_no_loss_ovf", ovf_cnt, 1);
    evt_ready = 1'b1;
    drain();

    // reset while repeating with three events queued
    evt_ready = 1'b0;
    key_lvl = 2'b01;
    press(2'b10);
    repeat (33) tick();
    check("pre_rst_state", int'(dut.state), int'(ST_REPT));
    check("pre_rst_count", int'(dut.u_fifo.count), 3);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", int'(evt_valid), 0);
    check("mid_rst_state", int'(dut.state), int'(ST_IDLE));
    check("mid_rst_drop", int'(drop_cnt), 0);
    tick();
    tick();
    rst_n = 1'b1;
    pop_cyc_q.delete();
    evt_ready = 1'b1;
    repeat (40) tick();
    check("post_rst_no_evt", pop_cyc_q.size(), 0);
    check("post_rst_state", int'(dut.state), int'(ST_IDLE));

    // drop counter saturation
    key_lvl = 2'b11;
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press(2'b01);
      tick();
      tick();
    end
    check("sat_start", int'(drop_cnt), 0);
    key_down = 2'b01;
    repeat (254) tick();
    check("sat_254", int'(drop_cnt), 254);
    repeat (46) tick();
    key_down = 2'b00;
    check("sat_255", int'(drop_cnt), 255);
    tick();
    check("sat_hold", int'(drop_cnt), 255);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
